// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC sequencer for the fetch stage.
// Picks the PC register input (sequential, branch target, exception vector or EPC)
// and its write enable, holds the PC through stalls and keeps a branch resolved
// during a stall as a pending redirect until the stall releases.
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : misaligned targets raise an address-error redirect to EXC_VEC (adel pulse)
//   undefined : target bits [1:0] are forced to 2'b00, adel stays 0
module pc_seq_ctrl #(
   parameter logic [31:0] RESET_VEC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_cur,
   input  logic        stall,
   input  logic        br_take,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] pc_next,
   output logic        pc_en,
   output logic        flush,
   output logic        redir_pend,
   output logic        adel
);

`ifdef PC_ALIGN_CHECK_EN
   localparam logic ALIGN_CHK = 1'b1;
`else
   localparam logic ALIGN_CHK = 1'b0;
`endif

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HOLD, ST_FLUSH} state_t;

   state_t      r_state;
   state_t      w_state_nx;
   logic        r_pend;
   logic [31:0] r_pend_tgt;
   logic        r_flush;
   logic        r_adel;

   logic        w_pend_nx;
   logic [31:0] w_pend_tgt_nx;
   logic        w_adel_nx;
   logic        w_stall_eff;
   logic        w_redirect;
   logic [31:0] w_tgt;
   logic [31:0] w_pc_inc;

   assign w_pc_inc   = pc_cur + 32'd4;
   assign flush      = r_flush;
   assign redir_pend = r_pend;
   assign adel       = r_adel;

   // Next-PC selection and next-state decode; all target loads share one alignment stage
   always_comb begin
      pc_next       = RESET_VEC;
      pc_en         = 1'b0;
      w_state_nx    = r_state;
      w_pend_nx     = r_pend;
      w_pend_tgt_nx = r_pend_tgt;
      w_adel_nx     = 1'b0;
      w_stall_eff   = 1'b0;
      w_redirect    = 1'b0;
      w_tgt         = '0;
      case (r_state)
         ST_BOOT: begin
            w_state_nx = ST_RUN;
         end
         ST_RUN, ST_FLUSH: begin
            // the flush cycle never freezes: it must load the redirect it follows
            w_stall_eff = stall && (r_state == ST_RUN);
            if (exc_req) begin
               pc_next    = EXC_VEC;
               pc_en      = 1'b1;
               w_state_nx = ST_FLUSH;
            end else if (eret_req) begin
               w_tgt      = epc;
               w_redirect = 1'b1;
               w_state_nx = ST_FLUSH;
            end else if (br_take && !w_stall_eff) begin
               w_tgt      = br_target;
               w_redirect = 1'b1;
               w_state_nx = ST_RUN;
            end else if (br_take) begin
               w_pend_nx     = 1'b1;
               w_pend_tgt_nx = br_target;
               w_state_nx    = ST_HOLD;
            end else if (w_stall_eff) begin
               w_state_nx = ST_HOLD;
            end else begin
               pc_next    = w_pc_inc;
               pc_en      = 1'b1;
               w_state_nx = ST_RUN;
            end
         end
         ST_HOLD: begin
            if (exc_req) begin
               w_pend_nx  = 1'b0;
               pc_next    = EXC_VEC;
               pc_en      = 1'b1;
               w_state_nx = ST_FLUSH;
            end else if (eret_req) begin
               w_pend_nx  = 1'b0;
               w_tgt      = epc;
               w_redirect = 1'b1;
               w_state_nx = ST_FLUSH;
            end else if (stall) begin
               // a branch resolving with nothing held yet is captured; a second one is dropped
               if (br_take && !r_pend) begin
                  w_pend_nx     = 1'b1;
                  w_pend_tgt_nx = br_target;
               end
            end else begin
               w_pend_nx  = 1'b0;
               w_state_nx = ST_RUN;
               if (r_pend) begin
                  w_tgt      = r_pend_tgt;
                  w_redirect = 1'b1;
               end else begin
                  pc_next = w_pc_inc;
                  pc_en   = 1'b1;
               end
            end
         end
         default: begin
            w_state_nx = ST_BOOT;
         end
      endcase

      if (w_redirect) begin
         pc_en = 1'b1;
         if (ALIGN_CHK && (w_tgt[1:0] != 2'b00)) begin
            pc_next    = EXC_VEC;
            w_adel_nx  = 1'b1;
            w_state_nx = ST_FLUSH;
         end else begin
            pc_next = {w_tgt[31:2], 2'b00};
         end
      end
   end

   // State, pending redirect and registered status pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_BOOT;
         r_pend     <= 1'b0;
         r_pend_tgt <= '0;
         r_flush    <= 1'b0;
         r_adel     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_pend     <= w_pend_nx;
         r_pend_tgt <= w_pend_tgt_nx;
         r_flush    <= (w_state_nx == ST_FLUSH);
         r_adel     <= w_adel_nx;
      end
   end

   // A second taken branch must not arrive while a redirect is already held
   a_no_br_while_pend : assert property (@(posedge clk) disable iff (!reset) !(r_pend && br_take))
      else $error("pc_seq_ctrl: br_take while a redirect is pending");

endmodule
